rob_ptr_ctrl: RTL

Head/tail pointer controller for the reorder buffer. Hands out ROB slot indices to rename/dispatch, retires entries in order from the head once the ROB reports them DONE, and sequences a full pipeline flush when the head entry carries an EXCEPTION, INTERRUPT or TRAP status. It sits beside the ROB storage array, sending it write and retire indices, and drives the global flush to the rest of the backend.

---
 rtl/rob_ptr_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rob_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// rob_ptr_ctrl -- reorder buffer head/tail pointer controller.
//
// Hands out ROB slot indices to dispatch from the tail and retires entries in
// order from the head. When the head entry reports EXCEPTION, INTERRUPT or
// TRAP, it sequences a one-cycle global flush. It then waits for the frontend
// redirect before accepting allocations again.
//
// Parameters:
//   ROB_ENTRIES  ROB depth; must be a power of two. IDX_W = $clog2(ROB_ENTRIES).
//
// Ports:
//   clk_in, rst_N_in        clock, asynchronous active-low reset
//   alloc_valid_in/ready_out   one-slot allocation handshake
//   alloc_ptr_out           tail slot index granted this cycle
//   commit_valid_in/ready_out  retire handshake for the head entry (DONE)
//   head_ptr_out            current head slot index
//   exc_valid_in            head entry is EXCEPTION/INTERRUPT/TRAP
//   exc_status_in           3-bit rob_pkg::status_t of the head entry,
//                           latched as-is into flush_cause_out
//   flush_out               one-cycle global flush pulse
//   flush_cause_out         latched cause; valid in FLUSH and WAIT_REDIRECT
//   redirect_in             frontend redirected; resume allocation
//   count_out/full_out/empty_out  occupancy status
//   commit_cnt_out, stall_cnt_out 32-bit saturating statistics
//
// Configuration macro: ROB_PTR_CTRL_STATS_EN
//   defined   -> retire and full-stall counters are implemented
//   undefined -> both statistic ports are tied to zero (no counter flops)
// ---------------------------------------------------------------------------
module rob_ptr_ctrl #(
    parameter  int ROB_ENTRIES = 128,
    localparam int IDX_W       = $clog2(ROB_ENTRIES)
) (
    input  logic             clk_in,
    input  logic             rst_N_in,
    input  logic             alloc_valid_in,
    output logic             alloc_ready_out,
    output logic [IDX_W-1:0] alloc_ptr_out,
    input  logic             commit_valid_in,
    output logic             commit_ready_out,
    output logic [IDX_W-1:0] head_ptr_out,
    input  logic             exc_valid_in,
    input  logic [2:0]       exc_status_in,
    output logic             flush_out,
    output logic [2:0]       flush_cause_out,
    input  logic             redirect_in,
    output logic [IDX_W:0]   count_out,
    output logic             full_out,
    output logic             empty_out,
    output logic [31:0]      commit_cnt_out,
    output logic [31:0]      stall_cnt_out
);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        WAIT_REDIRECT
    } state_t;

    localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    state_t         state;
    // The extra MSB is a wrap bit, so full and empty can be told apart when
    // the index bits match.
    logic [IDX_W:0] head;
    logic [IDX_W:0] tail;
    logic           flush_q;
    logic [2:0]     cause_q;

    logic alloc_fire;
    logic commit_fire;
    logic exc_take;

    assign count_out        = tail - head;
    assign full_out         = (head[IDX_W-1:0] == tail[IDX_W-1:0]) &&
                              (head[IDX_W] != tail[IDX_W]);
    assign empty_out        = (head == tail);
    assign alloc_ptr_out    = tail[IDX_W-1:0];
    assign head_ptr_out     = head[IDX_W-1:0];
    assign flush_out        = flush_q;
    assign flush_cause_out  = cause_q;

    // A full ROB stalls allocation even if the head retires this same cycle.
    assign alloc_ready_out  = (state == RUN) && !full_out;
    // An excepting head must never retire, so it blocks commit directly.
    assign commit_ready_out = (state == RUN) && !empty_out && !exc_valid_in;

    assign alloc_fire  = alloc_valid_in && alloc_ready_out;
    assign commit_fire = commit_valid_in && commit_ready_out;
    assign exc_take    = (state == RUN) && exc_valid_in && !empty_out;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order in the block.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state   <= RUN;
            head    <= '0;
            tail    <= '0;
            flush_q <= 1'b0;
            cause_q <= '0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                RUN: begin
                    // An allocation in the exception cycle still fires; the
                    // flush that follows squashes it.
                    if (alloc_fire)  tail <= tail + PTR_ONE;
                    if (commit_fire) head <= head + PTR_ONE;
                    if (exc_take) begin
                        state   <= FLUSH;
                        flush_q <= 1'b1;
                        cause_q <= exc_status_in;
                    end
                end
                FLUSH: begin
                    head  <= '0;
                    tail  <= '0;
                    state <= WAIT_REDIRECT;
                end
                WAIT_REDIRECT: begin
                    if (redirect_in) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef ROB_PTR_CTRL_STATS_EN
    logic [31:0] commit_cnt;
    logic [31:0] stall_cnt;

    // Counters survive flushes; only reset clears them. Both saturate.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            commit_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (commit_fire && (commit_cnt != 32'hFFFF_FFFF))
                commit_cnt <= commit_cnt + 32'd1;
            if ((state == RUN) && alloc_valid_in && full_out &&
                (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign commit_cnt_out = commit_cnt;
    assign stall_cnt_out  = stall_cnt;
`else
    assign commit_cnt_out = '0;
    assign stall_cnt_out  = '0;
`endif

endmodule
